// File: rtl/multicycle_controller.sv
//============================================================================
// multicycle_controller
//
// Control sequencer for the multi-cycle RV64 core. One shared memory port
// serves both instruction fetch and data access, so every instruction is
// stepped through FETCH -> DECODE -> EXECUTE/ADDR -> MEM -> WRITEBACK and
// this block drives every datapath strobe along the way.
//
// Optional feature macro:
//   PERF_CNT_EN  when defined, builds the cycle/retired-instruction
//                performance counters; when undefined both counter
//                outputs are tied to zero and no counter flops exist.
//
// Parameters:
//   MEM_WAIT_MAX  wait cycles tolerated in a memory state before the
//                 access is declared timed out (1..255)
//   CNT_WIDTH     width of the performance counters
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   opcode        instruction[6:0] from the instruction register
//   zero          ALU zero flag (branch condition)
//   mem_ready     memory finished the current access this cycle
//   halt_req      external halt request, honoured only between instructions
//   pc_write      load PC
//   pc_source     0 = PC+4, 1 = branch target
//   ir_write      load instruction register
//   mem_read      memory read strobe
//   mem_write     memory write strobe
//   mem_addr_sel  0 = PC address, 1 = ALU result
//   alu_src_b     0 = rs2, 1 = immediate
//   alu_op        00 add, 01 sub/compare, 10 funct-decoded
//   reg_write     register file write enable
//   mem_to_reg    0 = ALU result, 1 = memory data
//   state         current state encoding
//   halted        high while in HALT
//   error         sticky, high in ERROR
//   mem_timeout   sticky, ERROR was reached through a memory timeout
//   cycle_count   non-reset, non-ERROR cycles (PERF_CNT_EN only)
//   instr_count   retired instructions (PERF_CNT_EN only)
//============================================================================
module multicycle_controller #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    input  logic                 halt_req,
    output logic                 pc_write,
    output logic                 pc_source,
    output logic                 ir_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_addr_sel,
    output logic                 alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic [3:0]           state,
    output logic                 halted,
    output logic                 error,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count
);

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC_R = 4'd2,
        ST_EXEC_I = 4'd3,
        ST_ADDR   = 4'd4,
        ST_MEM_RD = 4'd5,
        ST_MEM_WR = 4'd6,
        ST_WB_ALU = 4'd7,
        ST_WB_MEM = 4'd8,
        ST_BRANCH = 4'd9,
        ST_HALT   = 4'd10,
        ST_ERROR  = 4'd11
    } state_t;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam int              WAIT_W     = 8;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

    state_t              state_q;
    state_t              state_d;
    logic [WAIT_W-1:0]   wait_q;
    logic                exec_imm_q;
    logic                error_q;
    logic                timeout_q;
    logic                timeout_hit;
    logic                mem_wait_active;

    // State register. Reset dominates everything; otherwise the next state
    // computed by the combinational block below is taken every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory wait counter. It counts cycles spent in a memory state without
    // mem_ready and is cleared on every state change, so each access gets
    // its own fresh timeout window. A zero count in FETCH also marks the
    // first cycle of a fetch, which is the only point where a halt request
    // may be honoured.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= '0;
        end else if (state_d != state_q) begin
            wait_q <= '0;
        end else if (mem_wait_active && !mem_ready) begin
            wait_q <= wait_q + WAIT_W'(1);
        end
    end

    // WB_ALU keeps the ALU operand selection of the EXEC state before it so
    // the result stays stable while the register file writes it. This flag
    // remembers whether that EXEC state used the immediate.
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_imm_q <= 1'b0;
        end else if (state_q == ST_EXEC_R) begin
            exec_imm_q <= 1'b0;
        end else if (state_q == ST_EXEC_I) begin
            exec_imm_q <= 1'b1;
        end
    end

    // Sticky error flags. Both are set on the transition into ERROR and
    // only reset can clear them; mem_timeout additionally records that the
    // cause was a memory access that never completed.
    always_ff @(posedge clk) begin
        if (reset) begin
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (state_d == ST_ERROR) begin
                error_q <= 1'b1;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Next-state and strobe decode. Strobes are mostly Moore (state only),
    // but the fetch/memory completion strobes react to mem_ready and the
    // branch PC write follows the zero flag in the same cycle. While reset
    // is high every strobe is held low regardless of the current state.
    // The timeout check runs after the per-state decode so that mem_ready
    // arriving on the last permitted cycle still completes the access.
    always_comb begin
        state_d         = state_q;
        pc_write        = 1'b0;
        pc_source       = 1'b0;
        ir_write        = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_addr_sel    = 1'b0;
        alu_src_b       = 1'b0;
        alu_op          = ALU_ADD;
        reg_write       = 1'b0;
        mem_to_reg      = 1'b0;
        timeout_hit     = 1'b0;
        mem_wait_active = 1'b0;

        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    if ((wait_q == '0) && halt_req) begin
                        state_d = ST_HALT;
                    end else begin
                        mem_read        = 1'b1;
                        mem_addr_sel    = 1'b0;
                        mem_wait_active = 1'b1;
                        if (mem_ready) begin
                            ir_write  = 1'b1;
                            pc_write  = 1'b1;
                            pc_source = 1'b0;
                            alu_op    = ALU_ADD;
                            state_d   = ST_DECODE;
                        end
                    end
                end

                ST_DECODE: begin
                    case (opcode)
                        OP_R_TYPE: state_d = ST_EXEC_R;
                        OP_I_TYPE: state_d = ST_EXEC_I;
                        OP_LOAD,
                        OP_STORE:  state_d = ST_ADDR;
                        OP_BRANCH: state_d = ST_BRANCH;
                        default:   state_d = ST_ERROR;
                    endcase
                end

                ST_EXEC_R: begin
                    alu_src_b = 1'b0;
                    alu_op    = ALU_FUNCT;
                    state_d   = ST_WB_ALU;
                end

                ST_EXEC_I: begin
                    alu_src_b = 1'b1;
                    alu_op    = ALU_FUNCT;
                    state_d   = ST_WB_ALU;
                end

                ST_ADDR: begin
                    alu_src_b = 1'b1;
                    alu_op    = ALU_ADD;
                    state_d   = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
                end

                ST_MEM_RD: begin
                    mem_read        = 1'b1;
                    mem_addr_sel    = 1'b1;
                    alu_src_b       = 1'b1;
                    alu_op          = ALU_ADD;
                    mem_wait_active = 1'b1;
                    if (mem_ready) begin
                        state_d = ST_WB_MEM;
                    end
                end

                ST_MEM_WR: begin
                    mem_write       = 1'b1;
                    mem_addr_sel    = 1'b1;
                    alu_src_b       = 1'b1;
                    alu_op          = ALU_ADD;
                    mem_wait_active = 1'b1;
                    if (mem_ready) begin
                        state_d = ST_FETCH;
                    end
                end

                ST_WB_ALU: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b0;
                    alu_src_b  = exec_imm_q;
                    alu_op     = ALU_FUNCT;
                    state_d    = ST_FETCH;
                end

                ST_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = ST_FETCH;
                end

                ST_BRANCH: begin
                    alu_src_b = 1'b0;
                    alu_op    = ALU_SUB;
                    pc_source = 1'b1;
                    pc_write  = zero;
                    state_d   = ST_FETCH;
                end

                ST_HALT: begin
                    if (!halt_req) begin
                        state_d = ST_FETCH;
                    end
                end

                ST_ERROR: begin
                    state_d = ST_ERROR;
                end

                default: begin
                    state_d = ST_ERROR;
                end
            endcase

            if (mem_wait_active && !mem_ready && (wait_q == WAIT_LIMIT)) begin
                timeout_hit = 1'b1;
                state_d     = ST_ERROR;
            end
        end
    end

    assign state       = state_q;
    assign halted      = (state_q == ST_HALT);
    assign error       = error_q;
    assign mem_timeout = timeout_q;

`ifdef PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cycle_q;
    logic [CNT_WIDTH-1:0] instr_q;
    logic                 retire;

    // An instruction retires on any transition back into FETCH that ends
    // an instruction; leaving HALT is not a retirement.
    assign retire = (state_q == ST_WB_ALU) ||
                    (state_q == ST_WB_MEM) ||
                    (state_q == ST_BRANCH) ||
                    ((state_q == ST_MEM_WR) && mem_ready);

    // Performance counters. Both wrap naturally; the cycle counter freezes
    // once the machine is parked in ERROR so the values describe the run
    // that led up to the fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (state_q != ST_ERROR) begin
                cycle_q <= cycle_q + CNT_WIDTH'(1);
            end
            if (retire) begin
                instr_q <= instr_q + CNT_WIDTH'(1);
            end
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
//============================================================================
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. A table of per-cycle records
// (inputs plus the state and strobes expected in that cycle) is replayed
// against the DUT, followed by hand-written sequences for the memory
// timeout boundary and the performance counters. The DUT is built with a
// wait limit of 4 so the timeout corner stays short.
//============================================================================
module tb_multicycle_controller;

    localparam int WAIT_MAX = 4;
    localparam int CW       = 32;

`ifdef PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC_R = 4'd2;
    localparam logic [3:0] S_EXEC_I = 4'd3;
    localparam logic [3:0] S_ADDR   = 4'd4;
    localparam logic [3:0] S_MEM_RD = 4'd5;
    localparam logic [3:0] S_MEM_WR = 4'd6;
    localparam logic [3:0] S_WB_ALU = 4'd7;
    localparam logic [3:0] S_WB_MEM = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_HALT   = 4'd10;
    localparam logic [3:0] S_ERROR  = 4'd11;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // Expected output bundles, packed as
    // {pc_write, pc_source, ir_write, mem_read, mem_write, mem_addr_sel,
    //  alu_src_b, alu_op[1:0], reg_write, mem_to_reg, halted, error,
    //  mem_timeout}
    localparam logic [13:0] O_NONE       = 14'd0;
    localparam logic [13:0] O_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [13:0] O_FETCH_RDY  = {1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [13:0] O_EXR        = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [13:0] O_EXI        = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [13:0] O_ADDR       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [13:0] O_MRD        = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [13:0] O_MWR        = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [13:0] O_WBA_R      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,1'b0,1'b0,1'b0,1'b0};
    localparam logic [13:0] O_WBA_I      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b1,1'b0,1'b0,1'b0,1'b0};
    localparam logic [13:0] O_WBM        = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0};
    localparam logic [13:0] O_BR_Z       = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [13:0] O_BR_NZ      = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [13:0] O_HALT       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0};
    localparam logic [13:0] O_ERR        = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0};
    localparam logic [13:0] O_ERR_TO     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1};

    typedef struct {
        logic [6:0]  op;
        logic        rdy;
        logic        z;
        logic        hreq;
        logic [3:0]  st;
        logic [13:0] outs;
    } vec_t;

    logic          clk;
    logic          reset;
    logic [6:0]    opcode;
    logic          zero;
    logic          mem_ready;
    logic          halt_req;
    logic          pc_write;
    logic          pc_source;
    logic          ir_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_addr_sel;
    logic          alu_src_b;
    logic [1:0]    alu_op;
    logic          reg_write;
    logic          mem_to_reg;
    logic [3:0]    state;
    logic          halted;
    logic          error;
    logic          mem_timeout;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] instr_count;
    logic [13:0]   obs;

    int compared   = 0;
    int mismatched = 0;
    vec_t vecs[$];

    multicycle_controller #(
        .MEM_WAIT_MAX (WAIT_MAX),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .halt_req     (halt_req),
        .pc_write     (pc_write),
        .pc_source    (pc_source),
        .ir_write     (ir_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr_sel (mem_addr_sel),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .state        (state),
        .halted       (halted),
        .error        (error),
        .mem_timeout  (mem_timeout),
        .cycle_count  (cycle_count),
        .instr_count  (instr_count)
    );

    assign obs = {pc_write, pc_source, ir_write, mem_read, mem_write, mem_addr_sel,
                  alu_src_b, alu_op, reg_write, mem_to_reg, halted, error, mem_timeout};

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input logic [6:0] op, input logic rdy, input logic z,
                                input logic h, input logic [3:0] st, input logic [13:0] o);
        vec_t v;
        v.op   = op;
        v.rdy  = rdy;
        v.z    = z;
        v.hreq = h;
        v.st   = st;
        v.outs = o;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, let the combinational
    // strobes settle, compare, and leave the next rising edge to advance.
    task automatic applyStimulus(input vec_t v, input string name);
        @(negedge clk);
        reset     = 1'b0;
        opcode    = v.op;
        mem_ready = v.rdy;
        zero      = v.z;
        halt_req  = v.hreq;
        #2;
        checkOutput({name, " state"},   {28'd0, state}, {28'd0, v.st});
        checkOutput({name, " strobes"}, {18'd0, obs},   {18'd0, v.outs});
    endtask

    // Reset over two edges with mem_ready high to confirm strobes stay low.
    task automatic resetDut(input string name);
        @(negedge clk);
        reset     = 1'b1;
        opcode    = OP_R;
        mem_ready = 1'b1;
        zero      = 1'b1;
        halt_req  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput({name, " reset state"},   {28'd0, state}, {28'd0, S_FETCH});
        checkOutput({name, " reset strobes"}, {18'd0, obs},   {18'd0, O_NONE});
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 7'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        halt_req  = 1'b0;

        // R-type, mem_ready always high: FETCH, DECODE, EXEC_R, WB_ALU
        vecs.push_back(mk(OP_R, 1, 0, 0, S_FETCH,  O_FETCH_RDY));
        vecs.push_back(mk(OP_R, 1, 0, 0, S_DECODE, O_NONE));
        vecs.push_back(mk(OP_R, 1, 0, 0, S_EXEC_R, O_EXR));
        vecs.push_back(mk(OP_R, 1, 0, 0, S_WB_ALU, O_WBA_R));
        // I-type: WB_ALU keeps the immediate operand select
        vecs.push_back(mk(OP_I, 1, 0, 0, S_FETCH,  O_FETCH_RDY));
        vecs.push_back(mk(OP_I, 1, 0, 0, S_DECODE, O_NONE));
        vecs.push_back(mk(OP_I, 1, 0, 0, S_EXEC_I, O_EXI));
        vecs.push_back(mk(OP_I, 1, 0, 0, S_WB_ALU, O_WBA_I));
        // Load with three wait cycles in MEM_RD: 8 cycles in total
        vecs.push_back(mk(OP_LD, 1, 0, 0, S_FETCH,  O_FETCH_RDY));
        vecs.push_back(mk(OP_LD, 1, 0, 0, S_DECODE, O_NONE));
        vecs.push_back(mk(OP_LD, 0, 0, 0, S_ADDR,   O_ADDR));
        vecs.push_back(mk(OP_LD, 0, 0, 0, S_MEM_RD, O_MRD));
        vecs.push_back(mk(OP_LD, 0, 0, 0, S_MEM_RD, O_MRD));
        vecs.push_back(mk(OP_LD, 0, 0, 0, S_MEM_RD, O_MRD));
        vecs.push_back(mk(OP_LD, 1, 0, 0, S_MEM_RD, O_MRD));
        vecs.push_back(mk(OP_LD, 1, 0, 0, S_WB_MEM, O_WBM));
        // Branch taken
        vecs.push_back(mk(OP_BR, 1, 1, 0, S_FETCH,  O_FETCH_RDY));
        vecs.push_back(mk(OP_BR, 1, 1, 0, S_DECODE, O_NONE));
        vecs.push_back(mk(OP_BR, 1, 1, 0, S_BRANCH, O_BR_Z));
        // Branch not taken
        vecs.push_back(mk(OP_BR, 1, 0, 0, S_FETCH,  O_FETCH_RDY));
        vecs.push_back(mk(OP_BR, 1, 0, 0, S_DECODE, O_NONE));
        vecs.push_back(mk(OP_BR, 1, 0, 0, S_BRANCH, O_BR_NZ));
        // One fetch wait cycle, then an R-type
        vecs.push_back(mk(OP_R, 0, 0, 0, S_FETCH,  O_FETCH_WAIT));
        vecs.push_back(mk(OP_R, 1, 0, 0, S_FETCH,  O_FETCH_RDY));
        vecs.push_back(mk(OP_R, 1, 0, 0, S_DECODE, O_NONE));
        vecs.push_back(mk(OP_R, 1, 0, 0, S_EXEC_R, O_EXR));
        vecs.push_back(mk(OP_R, 1, 0, 0, S_WB_ALU, O_WBA_R));
        // Store with halt requested from DECODE: store completes, then HALT
        vecs.push_back(mk(OP_ST, 1, 0, 0, S_FETCH,  O_FETCH_RDY));
        vecs.push_back(mk(OP_ST, 1, 0, 1, S_DECODE, O_NONE));
        vecs.push_back(mk(OP_ST, 1, 0, 1, S_ADDR,   O_ADDR));
        vecs.push_back(mk(OP_ST, 1, 0, 1, S_MEM_WR, O_MWR));
        vecs.push_back(mk(OP_ST, 1, 0, 1, S_FETCH,  O_NONE));
        vecs.push_back(mk(OP_ST, 1, 0, 1, S_HALT,   O_HALT));
        vecs.push_back(mk(OP_R,  1, 0, 0, S_HALT,   O_HALT));
        vecs.push_back(mk(OP_R,  1, 0, 0, S_FETCH,  O_FETCH_RDY));
        vecs.push_back(mk(OP_R,  1, 0, 0, S_DECODE, O_NONE));
        vecs.push_back(mk(OP_R,  1, 0, 0, S_EXEC_R, O_EXR));
        vecs.push_back(mk(OP_R,  1, 0, 0, S_WB_ALU, O_WBA_R));
        // Illegal opcode: ERROR is sticky and ignores mem_ready/halt_req
        vecs.push_back(mk(OP_BAD, 1, 0, 0, S_FETCH,  O_FETCH_RDY));
        vecs.push_back(mk(OP_BAD, 1, 0, 0, S_DECODE, O_NONE));
        vecs.push_back(mk(OP_BAD, 1, 0, 0, S_ERROR,  O_ERR));
        vecs.push_back(mk(OP_R,   1, 0, 1, S_ERROR,  O_ERR));

        resetDut("initial");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Timeout: mem_ready stuck low in FETCH. The counter walks 0..4 and
        // the cycle that finds it at 4 with no ready goes to ERROR.
        resetDut("timeout");
        for (int i = 0; i < WAIT_MAX + 1; i++) begin
            applyStimulus(mk(OP_R, 0, 0, 0, S_FETCH, O_FETCH_WAIT), $sformatf("to_wait%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(OP_R, 1, 0, 0, S_ERROR, O_ERR_TO), $sformatf("to_err%0d", i));
        end

        // Ready arriving in the very cycle the limit is reached wins.
        resetDut("ready_wins");
        for (int i = 0; i < WAIT_MAX; i++) begin
            applyStimulus(mk(OP_R, 0, 0, 0, S_FETCH, O_FETCH_WAIT), $sformatf("rw_wait%0d", i));
        end
        applyStimulus(mk(OP_R, 1, 0, 0, S_FETCH,  O_FETCH_RDY), "rw_last");
        applyStimulus(mk(OP_R, 1, 0, 0, S_DECODE, O_NONE),      "rw_decode");

        // Performance counters: three R-types then an illegal opcode.
        resetDut("perf");
        for (int n = 0; n < 3; n++) begin
            applyStimulus(mk(OP_R, 1, 0, 0, S_FETCH,  O_FETCH_RDY), $sformatf("perf%0d_f", n));
            applyStimulus(mk(OP_R, 1, 0, 0, S_DECODE, O_NONE),      $sformatf("perf%0d_d", n));
            applyStimulus(mk(OP_R, 1, 0, 0, S_EXEC_R, O_EXR),       $sformatf("perf%0d_e", n));
            applyStimulus(mk(OP_R, 1, 0, 0, S_WB_ALU, O_WBA_R),     $sformatf("perf%0d_w", n));
        end
        applyStimulus(mk(OP_BAD, 1, 0, 0, S_FETCH, O_FETCH_RDY), "perf_bad_f");
        checkOutput("cycle_count after 3 R", cycle_count, PERF_ON ? 32'd12 : 32'd0);
        checkOutput("instr_count after 3 R", instr_count, PERF_ON ? 32'd3  : 32'd0);
        applyStimulus(mk(OP_BAD, 1, 0, 0, S_DECODE, O_NONE), "perf_bad_d");
        applyStimulus(mk(OP_BAD, 1, 0, 0, S_ERROR,  O_ERR),  "perf_err0");
        checkOutput("cycle_count entering ERROR", cycle_count, PERF_ON ? 32'd14 : 32'd0);
        applyStimulus(mk(OP_BAD, 1, 0, 0, S_ERROR, O_ERR), "perf_err1");
        applyStimulus(mk(OP_BAD, 1, 0, 0, S_ERROR, O_ERR), "perf_err2");
        checkOutput("cycle_count frozen",  cycle_count, PERF_ON ? 32'd14 : 32'd0);
        checkOutput("instr_count frozen",  instr_count, PERF_ON ? 32'd3  : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control sequencer that converts the single-cycle RV64 datapath into a multi-cycle machine sharing one memory port for fetch and data.
Moore/Mealy FSM steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK and drives every datapath strobe.
Handles a memory-ready handshake, a timeout, an external halt request and illegal opcodes.
Sits beside the register file, ALU and memory at CPU top level, replacing the single-cycle control unit.

Parameters:
MEM_WAIT_MAX, 15, max cycles waiting for mem_ready in any memory state before timeout (1..255)
CNT_WIDTH, 32, width of performance counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  7  instruction[6:0] from the instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory completed current access this cycle
halt_req  input  1  external halt request
pc_write  output  1  load PC
pc_source  output  1  0 = PC+4, 1 = branch target
ir_write  output  1  load instruction register
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr_sel  output  1  0 = PC address, 1 = ALU result
alu_src_b  output  1  0 = rs2, 1 = immediate
alu_op  output  2  to ALU control: 00 add, 01 sub/compare, 10 funct-decoded
reg_write  output  1  register file write enable
mem_to_reg  output  1  0 = ALU result, 1 = memory data
state  output  4  current state encoding
halted  output  1  high in HALT
error  output  1  sticky; high in ERROR
mem_timeout  output  1  sticky; ERROR was entered by timeout
cycle_count  output  CNT_WIDTH  see Optional Feature
instr_count  output  CNT_WIDTH  see Optional Feature

Behaviour:
- States: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, HALT=10, ERROR=11.
- Reset (sync, dominates all inputs): state=FETCH, wait counter=0, error=0, mem_timeout=0, counters=0. All strobes are 0 while reset is high.
- FETCH:
  - First cycle (wait counter=0) with halt_req=1: go HALT; no memory access.
  - Otherwise: mem_read=1, mem_addr_sel=0.
  - When mem_ready=1 (same cycle): ir_write=1, pc_write=1, pc_source=0, alu_op=00; go DECODE.
- DECODE: no strobes. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - any other -> ERROR (error=1)
- EXEC_R: alu_src_b=0, alu_op=10; go WB_ALU.
- EXEC_I: alu_src_b=1, alu_op=10; go WB_ALU.
- ADDR: alu_src_b=1, alu_op=00; go MEM_RD for a load, MEM_WR for a store. The opcode is held stable by the instruction register.
- MEM_RD: mem_read=1, mem_addr_sel=1, alu_src_b=1, alu_op=00. On mem_ready go WB_MEM.
- MEM_WR: mem_write=1, mem_addr_sel=1, alu_src_b=1, alu_op=00. On mem_ready go FETCH (retire).
- WB_ALU: reg_write=1, mem_to_reg=0. Holds the alu_src_b/alu_op of the preceding EXEC state. Go FETCH (retire).
- WB_MEM: reg_write=1, mem_to_reg=1; go FETCH (retire).
- BRANCH: alu_src_b=0, alu_op=01, pc_source=1, pc_write=zero (combinational); go FETCH (retire).
- HALT: halted=1, no strobes. Leave to FETCH the cycle after halt_req=0. Halt is never taken mid-instruction.
- ERROR: all strobes 0; sticky until reset.
- Wait counter:
  - Increments each cycle in FETCH/MEM_RD/MEM_WR while mem_ready=0; clears on every state change.
  - If the counter reaches MEM_WAIT_MAX with mem_ready=0: go ERROR with mem_timeout=1.
  - mem_ready=1 in that same cycle wins: access completes, no timeout.
- Latency with mem_ready held 1: R/I = 4 cycles, load = 5, store = 4, branch = 3. Each memory wait cycle adds 1.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.

Optional Feature:
PERF_CNT_EN defined:
- cycle_count increments every non-reset cycle except in ERROR.
- instr_count increments on each retire transition into FETCH.
- Both wrap modulo 2^CNT_WIDTH.

PERF_CNT_EN undefined: both outputs are constant 0 and no counter flops are built.

Test Plan:
- Reset, mem_ready=1, opcode=0110011 -> states 0,1,2,7,0; reg_write=1 only in the 4th cycle; ir_write/pc_write=1 in the 1st cycle.
- Load (0000011) with mem_ready low 3 cycles in MEM_RD -> 8 cycles total; mem_to_reg=1 with reg_write in WB_MEM.
- Branch (1100011):
  - zero=1 -> pc_write=1, pc_source=1 in BRANCH.
  - zero=0 -> pc_write=0; next state FETCH.
- MEM_WAIT_MAX=4, mem_ready held 0 in FETCH -> ERROR after 4 wait cycles; error=1, mem_timeout=1; stays until reset.
- halt_req=1 during DECODE of a store -> store completes (mem_write pulse), then HALT; halt_req=0 -> FETCH next cycle.
- With PERF_CNT_EN, run 3 R-type instructions from reset -> instr_count=3, cycle_count=12; opcode 1111111 -> ERROR, counters freeze.
